// File: rtl/spi_master_if.sv
// Byte-stream and SPI pin bundle for spi_master.
// The master modport is the SPI master itself; the slave modport is the byte source/sink and SPI pins.
interface spi_master_if #(
  parameter int DIV_WIDTH = 32
);
  logic [DIV_WIDTH-1:0] spi_sclk_div_i;
  logic [7:0]           spi_byte_data_i;
  logic                 spi_byte_dc_i;
  logic                 spi_byte_last_i;
  logic                 spi_byte_vld_i;
  logic                 spi_byte_rdy_o;
  logic                 spi_miso_i;
  logic                 spi_sclk_o;
  logic                 spi_mosi_o;
  logic                 spi_cs_n_o;
  logic                 spi_dc_o;
  logic [7:0]           spi_byte_data_o;
  logic                 spi_byte_vld_o;

  modport master (
    input  spi_sclk_div_i, spi_byte_data_i, spi_byte_dc_i, spi_byte_last_i,
    input  spi_byte_vld_i, spi_miso_i,
    output spi_byte_rdy_o, spi_sclk_o, spi_mosi_o, spi_cs_n_o, spi_dc_o,
    output spi_byte_data_o, spi_byte_vld_o
  );

  modport slave (
    output spi_sclk_div_i, spi_byte_data_i, spi_byte_dc_i, spi_byte_last_i,
    output spi_byte_vld_i, spi_miso_i,
    input  spi_byte_rdy_o, spi_sclk_o, spi_mosi_o, spi_cs_n_o, spi_dc_o,
    input  spi_byte_data_o, spi_byte_vld_o
  );
endinterface

// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master, MSB first, with a D/C sideband pin.
// Bytes arrive on a valid/ready handshake; each received byte is returned as a one-cycle pulse.
module spi_master #(
  parameter int CS_IDLE_CYCLES = 2,
  parameter int DIV_WIDTH      = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  spi_master_if.master    bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e                state_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  cnt_q;
  logic [4:0]            edge_q;
  logic [7:0]            tx_q;
  logic [7:0]            rx_q;
  logic [7:0]            gap_q;
  logic                  last_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  cs_n_q;
  logic                  dc_q;
  logic                  rdy_q;
  logic [7:0]            data_q;
  logic                  vld_q;

  logic [DIV_WIDTH-1:0]  div_d;
  logic [4:0]            edge_d;
  logic                  accept_d;

  always_comb begin
    div_d    = (bus.spi_sclk_div_i == '0) ? DIV_WIDTH'(1) : bus.spi_sclk_div_i;
    edge_d   = edge_q + 5'd1;
    accept_d = (state_q == IDLE) && rdy_q && bus.spi_byte_vld_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= DIV_WIDTH'(1);
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // cs_n is left alone here so a burst stays open between bytes
          rdy_q <= 1'b1;
          if (accept_d) begin
            rdy_q   <= 1'b0;
            div_q   <= div_d;
            cnt_q   <= div_d - DIV_WIDTH'(1);
            last_q  <= bus.spi_byte_last_i;
            dc_q    <= bus.spi_byte_dc_i;
            mosi_q  <= bus.spi_byte_data_i[7];
            tx_q    <= {bus.spi_byte_data_i[6:0], 1'b0};
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            edge_q  <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[6:0], bus.spi_miso_i};
            edge_q  <= 5'd1;
            cnt_q   <= div_q - DIV_WIDTH'(1);
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            cnt_q  <= div_q - DIV_WIDTH'(1);
            edge_q <= edge_d;
            if (edge_d[0]) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[6:0], bus.spi_miso_i};
            end else begin
              sclk_q <= 1'b0;
              if (edge_d == 5'd16) begin
                data_q <= rx_q;
                vld_q  <= 1'b1;
                if (last_q) begin
                  state_q <= HOLD;
                end else begin
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
                end
              end else begin
                mosi_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
              end
            end
          end else begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q  <= 1'b1;
            gap_q   <= 8'(CS_IDLE_CYCLES);
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
          end
        end
        GAP: begin
          // rdy only rises once cs_n has been high for the full idle time
          if (gap_q == '0) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.spi_byte_rdy_o  = rdy_q;
  assign bus.spi_sclk_o      = sclk_q;
  assign bus.spi_mosi_o      = mosi_q;
  assign bus.spi_cs_n_o      = cs_n_q;
  assign bus.spi_dc_o        = dc_q;
  assign bus.spi_byte_data_o = data_q;
  assign bus.spi_byte_vld_o  = vld_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: timing, burst, divider, D/C, reset and stall cases.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int CS_IDLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.DIV_WIDTH(32)) bus ();

  spi_master #(.CS_IDLE_CYCLES(CS_IDLE), .DIV_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model: fixed pattern shifted out MSB first per rising edge, or mosi loopback
  logic       loopback = 1'b0;
  logic [7:0] pat = 8'h00;
  int         pat_base = 0;
  int         rise_n = 0;
  assign bus.spi_miso_i = loopback ? bus.spi_mosi_o : pat[3'd7 - 3'(rise_n - pat_base)];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         rise_cyc[$];
  int         csn_rise_cyc[$];
  int         vld_cyc[$];
  logic [7:0] vld_dat[$];
  int         dc_chg_cyc[$];
  logic [7:0] mosi_cap = 8'h00;
  logic       prev_sclk = 1'b0;
  logic       prev_csn = 1'b1;
  logic       prev_dc = 1'b0;

  always @(negedge clk) begin
    if (bus.spi_sclk_o === 1'b1 && prev_sclk === 1'b0) begin
      rise_n = rise_n + 1;
      rise_cyc.push_back(cyc);
      mosi_cap = {mosi_cap[6:0], bus.spi_mosi_o};
    end
    if (bus.spi_cs_n_o === 1'b1 && prev_csn === 1'b0) csn_rise_cyc.push_back(cyc);
    if (bus.spi_byte_vld_o === 1'b1) begin
      vld_cyc.push_back(cyc);
      vld_dat.push_back(bus.spi_byte_data_o);
    end
    if (bus.spi_dc_o !== prev_dc) dc_chg_cyc.push_back(cyc);
    prev_sclk = bus.spi_sclk_o;
    prev_csn  = bus.spi_cs_n_o;
    prev_dc   = bus.spi_dc_o;
  end

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(output int c);
    int k;
    k = 0;
    while (bus.spi_byte_rdy_o !== 1'b1 && k < 500) begin
      tick();
      k++;
    end
    if (bus.spi_byte_rdy_o !== 1'b1) check_b("rdy_timeout", bus.spi_byte_rdy_o, 1'b1);
    c = cyc;
  endtask

  task automatic send(input logic [7:0] data, input logic dc, input logic last,
                      input int div, output int t, output logic csn_at_accept);
    wait_rdy(t);
    csn_at_accept = bus.spi_cs_n_o;
    bus.spi_byte_data_i = data;
    bus.spi_byte_dc_i   = dc;
    bus.spi_byte_last_i = last;
    bus.spi_sclk_div_i  = div;
    bus.spi_byte_vld_i  = 1'b1;
    $display("send data=0x%02h dc=%b last=%b div=%0d accept_cycle=%0d", data, dc, last, div, t);
    tick();
    bus.spi_byte_vld_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, t3, ta, tb, c, a, rb, csb, vb, db, r, k;
    logic csn, ps;

    bus.spi_sclk_div_i  = 32'd1;
    bus.spi_byte_data_i = 8'h00;
    bus.spi_byte_dc_i   = 1'b0;
    bus.spi_byte_last_i = 1'b0;
    bus.spi_byte_vld_i  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check_b("rst_cs_n", bus.spi_cs_n_o, 1'b1);
    check_b("rst_sclk", bus.spi_sclk_o, 1'b0);
    check_b("rst_mosi", bus.spi_mosi_o, 1'b0);
    check_b("rst_dc",   bus.spi_dc_o, 1'b0);
    check_b("rst_rdy",  bus.spi_byte_rdy_o, 1'b0);
    check_b("rst_vld",  bus.spi_byte_vld_o, 1'b0);
    check_8("rst_data", bus.spi_byte_data_o, 8'h00);
    rst = 1'b0;
    tick();
    check_b("rdy_after_rst", bus.spi_byte_rdy_o, 1'b1);

    // Single byte, div=2
    loopback = 1'b0; pat = 8'h3C; pat_base = rise_n;
    rb = rise_cyc.size(); csb = csn_rise_cyc.size(); vb = vld_cyc.size(); db = dc_chg_cyc.size();
    send(8'hA5, 1'b1, 1'b1, 2, t, csn);
    check_b("s1_csn_low", bus.spi_cs_n_o, 1'b0);
    check_b("s1_dc", bus.spi_dc_o, 1'b1);
    check_b("s1_rdy_low", bus.spi_byte_rdy_o, 1'b0);
    wait_rdy(c);
    check_i("s1_rdy_cycle", c - t, 38);
    check_i("s1_rises", rise_cyc.size() - rb, 8);
    check_i("s1_first_rise", rise_cyc[rb] - t, 3);
    check_i("s1_last_rise", rise_cyc[rb + 7] - t, 31);
    check_8("s1_mosi", mosi_cap, 8'hA5);
    check_i("s1_vld_count", vld_cyc.size() - vb, 1);
    check_i("s1_vld_cycle", vld_cyc[vb] - t, 33);
    check_8("s1_rx", vld_dat[vb], 8'h3C);
    check_i("s1_csn_rise", csn_rise_cyc[csb] - t, 35);
    check_i("s1_dc_changes", dc_chg_cyc.size() - db, 1);
    check_i("s1_dc_change_cycle", dc_chg_cyc[db] - t, 1);
    $display("single byte: accept=%0d rdy_back=%0d", t, c);

    // Three-byte burst, div=1, loopback
    loopback = 1'b1;
    rb = rise_cyc.size(); csb = csn_rise_cyc.size(); vb = vld_cyc.size();
    send(8'h01, 1'b0, 1'b0, 1, t, csn);
    send(8'h80, 1'b0, 1'b0, 1, t2, csn);
    check_b("b_csn_held", csn, 1'b0);
    send(8'hFF, 1'b0, 1'b1, 1, t3, csn);
    wait_rdy(c);
    check_i("b_second_accept", t2 - t, 17);
    check_i("b_rises", rise_cyc.size() - rb, 24);
    check_i("b_interbyte", rise_cyc[rb + 8] - rise_cyc[rb + 7], 3);
    check_i("b_csn_rises", csn_rise_cyc.size() - csb, 1);
    check_i("b_vld_count", vld_cyc.size() - vb, 3);
    check_8("b_rx0", vld_dat[vb], 8'h01);
    check_8("b_rx1", vld_dat[vb + 1], 8'h80);
    check_8("b_rx2", vld_dat[vb + 2], 8'hFF);

    // Divider zero behaves as div=1
    loopback = 1'b0; pat = 8'hC3; pat_base = rise_n;
    rb = rise_cyc.size(); csb = csn_rise_cyc.size(); vb = vld_cyc.size();
    send(8'h5A, 1'b1, 1'b1, 0, t, csn);
    wait_rdy(c);
    check_i("d0_rises", rise_cyc.size() - rb, 8);
    check_i("d0_first_rise", rise_cyc[rb] - t, 2);
    check_i("d0_last_rise", rise_cyc[rb + 7] - t, 16);
    check_8("d0_mosi", mosi_cap, 8'h5A);
    check_i("d0_vld_cycle", vld_cyc[vb] - t, 17);
    check_8("d0_rx", vld_dat[vb], 8'hC3);
    check_i("d0_csn_rise", csn_rise_cyc[csb] - t, 18);

    // D/C switching between two single-byte bursts
    loopback = 1'b1;
    csb = csn_rise_cyc.size(); vb = vld_cyc.size(); db = dc_chg_cyc.size();
    send(8'h9A, 1'b0, 1'b1, 1, ta, csn);
    send(8'h33, 1'b1, 1'b1, 1, tb, csn);
    check_b("dc_csn_high_at_accept", csn, 1'b1);
    wait_rdy(c);
    check_i("dc_changes", dc_chg_cyc.size() - db, 2);
    check_i("dc_cmd_change", dc_chg_cyc[db] - ta, 1);
    check_i("dc_data_change", dc_chg_cyc[db + 1] - tb, 1);
    check_b("dc_csn_gap", ((tb + 1 - csn_rise_cyc[csb]) >= CS_IDLE), 1'b1);
    check_8("dc_rx0", vld_dat[vb], 8'h9A);
    check_8("dc_rx1", vld_dat[vb + 1], 8'h33);

    // Mid-byte reset after the 5th rising edge
    vb = vld_cyc.size();
    send(8'hFF, 1'b1, 1'b1, 2, t, csn);
    r = 0; k = 0; ps = bus.spi_sclk_o;
    while (r < 5 && k < 200) begin
      tick();
      if (bus.spi_sclk_o === 1'b1 && ps === 1'b0) r++;
      ps = bus.spi_sclk_o;
      k++;
    end
    check_i("mr_rises_seen", r, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_b("mr_csn", bus.spi_cs_n_o, 1'b1);
    check_b("mr_sclk", bus.spi_sclk_o, 1'b0);
    check_b("mr_mosi", bus.spi_mosi_o, 1'b0);
    check_b("mr_dc", bus.spi_dc_o, 1'b0);
    check_b("mr_rdy", bus.spi_byte_rdy_o, 1'b0);
    check_b("mr_vld", bus.spi_byte_vld_o, 1'b0);
    tick();
    check_b("mr_rdy_back", bus.spi_byte_rdy_o, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    check_i("mr_no_vld", vld_cyc.size() - vb, 0);
    send(8'h96, 1'b1, 1'b1, 1, t, csn);
    wait_rdy(c);
    check_i("mr_new_vld_count", vld_cyc.size() - vb, 1);
    check_8("mr_new_rx", vld_dat[vb], 8'h96);
    check_8("mr_new_mosi", mosi_cap, 8'h96);

    // Handshake stall with div change mid-byte
    rb = rise_cyc.size(); csb = csn_rise_cyc.size(); vb = vld_cyc.size();
    send(8'h6C, 1'b0, 1'b1, 3, t, csn);
    bus.spi_byte_data_i = 8'h11;
    bus.spi_byte_dc_i   = 1'b1;
    bus.spi_byte_last_i = 1'b1;
    bus.spi_sclk_div_i  = 32'd1;
    bus.spi_byte_vld_i  = 1'b1;
    k = 0;
    while (bus.spi_byte_rdy_o !== 1'b1 && k < 500) begin
      tick();
      k++;
    end
    a = cyc;
    $display("stall: first accept=%0d second accept=%0d", t, a);
    tick();
    bus.spi_byte_vld_i = 1'b0;
    wait_rdy(c);
    check_i("st_accept_cycle", a - t, 55);
    check_i("st_rises", rise_cyc.size() - rb, 16);
    check_i("st_spacing0", rise_cyc[rb + 7] - rise_cyc[rb], 42);
    check_i("st_spacing1", rise_cyc[rb + 15] - rise_cyc[rb + 8], 14);
    check_i("st_vld_count", vld_cyc.size() - vb, 2);
    check_8("st_rx0", vld_dat[vb], 8'h6C);
    check_8("st_rx1", vld_dat[vb + 1], 8'h11);
    check_i("st_csn_rises", csn_rise_cyc.size() - csb, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, plus a D/C sideband pin.
- It is the initiator counterpart of the on-chip SPI slave/RAM loader. It drives the slave's sclk/mosi/cs_n/dc pins from a second board or from a self-test harness on the same fabric.
- It accepts bytes over a valid/ready handshake and returns each byte captured from MISO as a one-cycle pulse.

Parameters:
- CS_IDLE_CYCLES, 2, minimum number of clk_i cycles cs_n stays high after a burst ends (1..255).
- DIV_WIDTH, 32, width of the sclk half-period divider input.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- spi_sclk_div_i  in  DIV_WIDTH  sclk half-period in clk_i cycles; 0 is treated as 1
- spi_byte_data_i  in  8  byte to transmit
- spi_byte_dc_i  in  1  D/C level driven for this byte
- spi_byte_last_i  in  1  1 = release cs_n after this byte
- spi_byte_vld_i  in  1  input byte valid
- spi_byte_rdy_o  out  1  ready to accept a byte
- spi_miso_i  in  1  serial data from slave
- spi_sclk_o  out  1  serial clock
- spi_mosi_o  out  1  serial data to slave
- spi_cs_n_o  out  1  chip select, active low
- spi_dc_o  out  1  data/command sideband
- spi_byte_data_o  out  8  byte received on MISO
- spi_byte_vld_o  out  1  one-cycle pulse, spi_byte_data_o is valid

Behaviour:
- All outputs are registered.
- Reset values: sclk 0, mosi 0, cs_n 1, dc 0, byte_rdy 0, byte_vld 0, byte_data 0x00.
- Reset takes effect on the next clk_i edge from any state and aborts a transfer mid-byte: cs_n goes high immediately and no byte_vld pulse is produced. byte_rdy rises on the first cycle after rst_i deasserts.
- States:
  - IDLE: rdy=1. cs_n holds its level; a burst may be open.
  - SETUP
  - SHIFT
  - HOLD
  - GAP
- Accept: a byte is accepted when vld_i&rdy_o in IDLE (cycle T). On acceptance the block latches data, dc, last and div (D = max(div,1)). rdy drops at T+1, then goes to SETUP.
- SETUP, entered at T+1: cs_n=0, dc driven, mosi=bit7, sclk=0. Lasts D cycles. The first rising edge is at T+1+D.
- SHIFT: sclk toggles every D cycles, 16 edges total, at T+1+kD for k=1..16.
  - Rising edge: miso is sampled into the shift register (LSB in) in the same cycle sclk goes high.
  - Falling edges k=2,4,..,14: mosi advances to the next bit.
  - The 16th edge (sclk low) ends the byte.
- Byte end at T+1+16D:
  - byte_data_o updates and byte_vld_o pulses for exactly one cycle.
  - last=0: go to IDLE with rdy=1 and cs_n held low. mosi holds bit0.
  - last=1: go to HOLD.
- HOLD: sclk 0, cs_n 0 for D cycles. cs_n goes high at T+1+17D, then enters GAP.
- GAP: cs_n 1 for CS_IDLE_CYCLES cycles, then IDLE with rdy=1.
- Back-to-back: vld_i held high with last=0 gives continuous bytes. Successive SETUP phases restart at T'+1 with cs_n staying low, so the inter-byte gap is 1 + D cycles of sclk low.
- Latching: dc is sampled per byte and holds its value until the next accept; it is unaffected by cs_n release. div changes are ignored during a byte.
- Inputs with vld_i=0 are don't-care. rdy_o does not depend combinationally on vld_i.
- Divider counter width is DIV_WIDTH. The counter reloads to D-1 on each edge and never wraps through 0 to max.

Test Plan:
- Single byte: div=2, data=0xA5, dc=1, last=1, miso tied to 0x3C pattern.
  - cs_n low at T+1, sclk rises at T+3,7,...,31, cs_n high at T+35.
  - mosi sampled at the rises reads 1,0,1,0,0,1,0,1.
  - vld pulse at T+33 with data 0x3C, dc=1 throughout; rdy returns at T+38.
- Burst: three bytes 0x01, 0x80, 0xFF, last only on the third, div=1, miso loopback from mosi.
  - cs_n stays low across the whole burst.
  - Three vld pulses with 0x01, 0x80, 0xFF.
  - Exactly 24 rising sclk edges, then a single cs_n rise.
- Divider zero: div=0, byte 0x5A.
  - Timing is identical to div=1: 16 sclk edges, one cycle apart.
  - Received byte equals the miso pattern.
- DC switching: a command byte with dc=0 followed by a data byte with dc=1, both last=1.
  - spi_dc_o changes only at T+1 of the second accept, while cs_n is high.
  - The cs_n high gap is at least CS_IDLE_CYCLES.
- Mid-byte reset: assert rst_i for one cycle after the 5th rising edge.
  - Next cycle: cs_n=1, sclk=0, mosi=0, dc=0, rdy=0, with no vld pulse.
  - rdy=1 one cycle after release; a new byte then transfers correctly.
- Handshake stall: vld_i high during SHIFT and GAP.
  - Not accepted until rdy_o=1; exactly one transfer per accepted byte.
  - Changing div mid-byte does not alter the edge spacing.
